// File: rtl/uart_tx_fifo_if.sv
// Byte-stream bundle between a producer, the uart_tx_fifo and uart_tx.
// Ports:
//   wr_data/wr_en           producer -> FIFO enqueue
//   full/empty/count        FIFO occupancy status
//   overflow                one-cycle pulse for a dropped write
//   uart_tx_busy            uart_tx -> FIFO, frame in progress
//   uart_tx_en/uart_tx_data FIFO -> uart_tx launch strobe and byte
// master: the environment (producer + transmitter); slave: the FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned DEPTH_LOG2   = 4
);
    logic [PAYLOAD_BITS-1:0] wr_data;
    logic                    wr_en;
    logic                    full;
    logic                    empty;
    logic [DEPTH_LOG2:0]     count;
    logic                    overflow;
    logic                    uart_tx_busy;
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;

    modport master (
        output wr_data, wr_en, uart_tx_busy,
        input  full, empty, count, overflow, uart_tx_en, uart_tx_data
    );

    modport slave (
        input  wr_data, wr_en, uart_tx_busy,
        output full, empty, count, overflow, uart_tx_en, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Elastic byte FIFO in front of uart_tx: absorbs bursts at clock rate and
// launches one byte per frame using the uart_tx_en / uart_tx_busy handshake.
// Ports:
//   clk   rising-edge system clock
//   reset asynchronous active-high reset
//   bus   uart_tx_fifo_if.slave (write side, status, transmitter handshake)
module uart_tx_fifo #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PAYLOAD_BITS-1:0] mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic                    tx_en_q, tx_en_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic                    wr_accept_c;
    logic                    pop_c;

    // Drain FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (!empty_q && !bus.uart_tx_busy) state_d = WAIT_START;
            WAIT_START: if (bus.uart_tx_busy)              state_d = WAIT_DONE;
            WAIT_DONE:  if (!bus.uart_tx_busy)             state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    // Drain FSM: outputs; a pop launches the head byte and advances rd_ptr
    always_comb begin
        pop_c     = 1'b0;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        if (state_q == IDLE && !empty_q && !bus.uart_tx_busy) begin
            pop_c     = 1'b1;
            tx_en_d   = 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
        end
    end

    // Storage, pointers and occupancy; full is judged on the pre-edge state,
    // so a write while full is dropped even if a pop happens in the same cycle
    always_comb begin
        wr_accept_c = bus.wr_en && !full_q;
        overflow_d  = bus.wr_en && full_q;

        mem_d = mem_q;
        if (wr_accept_c) begin
            mem_d[wr_ptr_q] = bus.wr_data;
        end

        wr_ptr_d = wr_accept_c ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_c       ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({wr_accept_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Register array carries no reset; occupancy state defines validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a scoreboard of expected bytes
// and a simple uart_tx model (busy for a fixed number of cycles per frame).
module tb_uart_tx_fifo;
    localparam int unsigned PB        = 8;
    localparam int unsigned DL2       = 4;
    localparam int unsigned FRAME_CYC = 20;

    logic clk;
    logic reset;
    logic force_busy;

    int          checks;
    int          failures;
    int          launch_cnt;
    int          ovf_cnt;
    int unsigned busy_cnt;
    logic        prev_en;
    logic        track;
    logic [7:0]  last_data;
    logic [7:0]  sb [$];

    uart_tx_fifo_if #(.PAYLOAD_BITS(PB), .DEPTH_LOG2(DL2)) bus ();

    uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.uart_tx_busy = force_busy | (busy_cnt != 0);

    // Transmitter model plus scoreboard consumer, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (reset) begin
            track   = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (bus.uart_tx_en === 1'b1) begin
                checks++;
                if (prev_en === 1'b1) begin
                    failures++;
                    $display("FAIL en_consecutive: uart_tx_en high two cycles in a row");
                end
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_launch: data=%02h, no byte expected", bus.uart_tx_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (bus.uart_tx_data !== exp_b) begin
                        failures++;
                        $display("FAIL tx_data: got %02h expected %02h", bus.uart_tx_data, exp_b);
                    end
                end
                last_data = bus.uart_tx_data;
                track     = 1'b1;
                launch_cnt++;
            end else if (track && busy_cnt != 0) begin
                checks++;
                if (bus.uart_tx_data !== last_data) begin
                    failures++;
                    $display("FAIL tx_data_stable: got %02h expected %02h", bus.uart_tx_data, last_data);
                end
            end
            if (bus.overflow === 1'b1) ovf_cnt++;
            prev_en = bus.uart_tx_en;
        end
        if (bus.uart_tx_en === 1'b1 && !reset) busy_cnt = FRAME_CYC;
        else if (busy_cnt != 0)                busy_cnt = busy_cnt - 1;
    end

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (!(sb.size() == 0 && busy_cnt == 0 && bus.empty === 1'b1 &&
                 bus.uart_tx_en === 1'b0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            failures++;
            $display("FAIL %s_drain_timeout: %0d bytes still expected after %0d cycles", tag, sb.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++;
        if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++;
        if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", bus.uart_tx_en); end
        checks++;
        if (bus.uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h expected 00", bus.uart_tx_data); end
    endtask

    task automatic test_single();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.count !== 5'd1) begin failures++; $display("FAIL single_count1: got %0d expected 1", bus.count); end
        checks++;
        if (bus.empty !== 1'b0) begin failures++; $display("FAIL single_empty0: got %b expected 0", bus.empty); end
        checks++;
        if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL single_en_early: got %b expected 0", bus.uart_tx_en); end
        @(negedge clk);
        checks++;
        if (bus.uart_tx_en !== 1'b1) begin failures++; $display("FAIL single_en_latency: got %b expected 1", bus.uart_tx_en); end
        checks++;
        if (bus.uart_tx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %02h expected a5", bus.uart_tx_data); end
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL single_count0: got %0d expected 0", bus.count); end
        checks++;
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty1: got %b expected 1", bus.empty); end
        wait_idle(100, "single");
    endtask

    task automatic test_burst_overflow();
        int ovf0 = ovf_cnt;
        int l0   = launch_cnt;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            sb.push_back(8'(i));
            @(negedge clk);
        end
        checks++;
        if (bus.full !== 1'b1) begin failures++; $display("FAIL burst_full: got %b expected 1", bus.full); end
        checks++;
        if (bus.count !== 5'd16) begin failures++; $display("FAIL burst_count: got %0d expected 16", bus.count); end
        bus.wr_data = 8'h55;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL burst_ovf_pulse: got %b expected 1", bus.overflow); end
        checks++;
        if (bus.count !== 5'd16) begin failures++; $display("FAIL burst_count_after_drop: got %0d expected 16", bus.count); end
        @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL burst_ovf_one_cycle: got %b expected 0", bus.overflow); end
        force_busy = 1'b0;
        wait_idle(16 * (FRAME_CYC + 10) + 50, "burst");
        checks++;
        if (launch_cnt - l0 !== 16) begin failures++; $display("FAIL burst_launches: got %0d expected 16", launch_cnt - l0); end
        checks++;
        if (ovf_cnt - ovf0 !== 1) begin failures++; $display("FAIL burst_ovf_count: got %0d expected 1", ovf_cnt - ovf0); end
    endtask

    task automatic test_wrap();
        int ovf0 = ovf_cnt;
        int l0   = launch_cnt;
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            while (bus.count >= 5'd14 && n < 200) begin
                @(negedge clk);
                n++;
            end
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'($urandom);
            sb.push_back(bus.wr_data);
            @(negedge clk);
            bus.wr_en = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle(40 * (FRAME_CYC + 10) + 50, "wrap");
        checks++;
        if (launch_cnt - l0 !== 40) begin failures++; $display("FAIL wrap_launches: got %0d expected 40", launch_cnt - l0); end
        checks++;
        if (ovf_cnt - ovf0 !== 0) begin failures++; $display("FAIL wrap_overflow: got %0d pulses expected 0", ovf_cnt - ovf0); end
    endtask

    task automatic test_full_pop();
        int ovf0 = ovf_cnt;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h80 + i);
            sb.push_back(8'(8'h80 + i));
            @(negedge clk);
        end
        force_busy  = 1'b0;
        bus.wr_data = 8'hC3;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checks++;
        if (bus.count !== 5'd15) begin failures++; $display("FAIL fullpop_count: got %0d expected 15", bus.count); end
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fullpop_ovf: got %b expected 1", bus.overflow); end
        checks++;
        if (bus.uart_tx_en !== 1'b1) begin failures++; $display("FAIL fullpop_en: got %b expected 1", bus.uart_tx_en); end
        @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf_one_cycle: got %b expected 0", bus.overflow); end
        wait_idle(16 * (FRAME_CYC + 10) + 50, "fullpop");
        checks++;
        if (ovf_cnt - ovf0 !== 1) begin failures++; $display("FAIL fullpop_ovf_count: got %0d expected 1", ovf_cnt - ovf0); end
    endtask

    task automatic test_reset_mid();
        int l0;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            sb.push_back(8'(8'h10 + i));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.count !== 5'd5) begin failures++; $display("FAIL midrst_precount: got %0d expected 5", bus.count); end
        #2 reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", bus.count); end
        checks++;
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL midrst_empty: got %b expected 1", bus.empty); end
        checks++;
        if (bus.uart_tx_en !== 1'b0) begin failures++; $display("FAIL midrst_en: got %b expected 0", bus.uart_tx_en); end
        checks++;
        if (bus.uart_tx_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %02h expected 00", bus.uart_tx_data); end
        @(negedge clk);
        #2 reset = 1'b0;
        l0 = launch_cnt;
        repeat (40) @(negedge clk);
        checks++;
        if (launch_cnt !== l0) begin failures++; $display("FAIL midrst_no_launch: got %0d launches expected 0", launch_cnt - l0); end
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL midrst_count_hold: got %0d expected 0", bus.count); end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h3C;
        sb.push_back(8'h3C);
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_idle(100, "midrst");
        checks++;
        if (launch_cnt - l0 !== 1) begin failures++; $display("FAIL midrst_relaunch: got %0d expected 1", launch_cnt - l0); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        launch_cnt  = 0;
        ovf_cnt     = 0;
        busy_cnt    = 0;
        prev_en     = 1'b0;
        track       = 1'b0;
        last_data   = 8'h00;
        force_busy  = 1'b0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst_overflow();
        test_wrap();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
